btn_move_ctrl: RTL and testbench

BTN_MOVE_CTRL -- requirements
Module: btn_move_ctrl

---
 rtl/btn_move_ctrl_pkg.sv | 41 ++++
 rtl/btn_debounce_fsm.sv | 122 ++++++++++++
 rtl/btn_move_ctrl.sv | 106 ++++++++++
 tb/tb_btn_move_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_move_ctrl_pkg.sv
// Shared maze definitions: direction codes, button FSM states and button indices.
package btn_move_ctrl_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } btn_state_e;

    // Bit positions in the packed button vectors, matching held = {C,R,L,D,U}.
    localparam int unsigned BTN_U   = 0;
    localparam int unsigned BTN_D   = 1;
    localparam int unsigned BTN_L   = 2;
    localparam int unsigned BTN_R   = 3;
    localparam int unsigned BTN_C   = 4;
    localparam int unsigned NUM_BTN = 5;
    localparam int unsigned NUM_DIR = 4;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Saturating add used by the drop counter; at most four events drop per cycle.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {6'b000000, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// One pushbutton: 2-flop synchronizer, debounce FSM and optional auto-repeat timer.
module btn_debounce_fsm
    import btn_move_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 500000,
    parameter int unsigned REP_DELAY  = 40000000,
    parameter int unsigned REP_PERIOD = 15000000,
    parameter bit          REP_EN     = 1'b1
) (
    input  logic ClkPort,
    input  logic Reset,
    input  logic raw,
    output logic held,
    output logic evt
);

    localparam int unsigned CNT_MAX = max3(DB_CYCLES, REP_DELAY, REP_PERIOD);
    localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DB_LAST      = CW'((DB_CYCLES > 0) ? DB_CYCLES - 1 : 0);
    localparam logic [CW-1:0] REP_DELAY_C  = CW'(REP_DELAY);
    localparam logic [CW-1:0] REP_PERIOD_C = CW'(REP_PERIOD);

    logic [1:0]  sync_q;
    logic        sync_lvl;
    btn_state_e  state_q, state_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [CW-1:0] rep_cnt_q, rep_cnt_d;
    logic        rep_first_q, rep_first_d;

    assign sync_lvl = sync_q[1];

    // Two-stage synchronizer on the raw asynchronous button level.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // State and counter registers.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_q     <= RELEASED;
            db_cnt_q    <= '0;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end

    // Debounce transitions plus repeat timing; rep_cnt only advances in PRESSED so it
    // holds its value across a RELEASE_WAIT bounce.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        evt         = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (sync_lvl) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_lvl) begin
                    state_d  = RELEASED;
                    db_cnt_d = '0;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d     = PRESSED;
                    db_cnt_d    = '0;
                    evt         = 1'b1;
                    // First PRESSED cycle counts as 1, so the repeat fires REP_DELAY
                    // cycles after this press cycle.
                    rep_cnt_d   = CW'(1);
                    rep_first_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!sync_lvl) begin
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = '0;
                end
                if (REP_EN) begin
                    if (rep_cnt_q >= (rep_first_q ? REP_DELAY_C : REP_PERIOD_C)) begin
                        evt         = 1'b1;
                        rep_cnt_d   = CW'(1);
                        rep_first_d = 1'b0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CW'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                if (sync_lvl) begin
                    state_d  = PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d  = RELEASED;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    assign held = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/btn_move_ctrl.sv
// Five debounced buttons feeding a one-entry move request register and a center pulse.
module btn_move_ctrl
    import btn_move_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 500000,
    parameter int unsigned REP_DELAY  = 40000000,
    parameter int unsigned REP_PERIOD = 15000000
) (
    input  logic       ClkPort,
    input  logic       Reset,
    input  logic       BtnU,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       BtnC,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       center_pulse,
    output logic [4:0] held,
    output logic [7:0] drop_cnt
);

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] held_vec;
    logic [NUM_BTN-1:0] evt_vec;

    logic [NUM_DIR-1:0] dir_evt;
    dir_e               win_dir;
    logic [2:0]         n_evt;
    logic               can_load;
    logic [2:0]         drop_inc;

    logic               move_valid_q;
    dir_e               move_dir_q;
    logic               center_q;
    logic [7:0]         drop_cnt_q;

    assign raw_vec = {BtnC, BtnR, BtnL, BtnD, BtnU};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce_fsm #(
            .DB_CYCLES (DB_CYCLES),
            .REP_DELAY (REP_DELAY),
            .REP_PERIOD(REP_PERIOD),
            .REP_EN    (i != BTN_C)
        ) u_fsm (
            .ClkPort(ClkPort),
            .Reset  (Reset),
            .raw    (raw_vec[i]),
            .held   (held_vec[i]),
            .evt    (evt_vec[i])
        );
    end

    // Fixed-priority arbitration U > D > L > R and count of events that will be lost.
    always_comb begin
        dir_evt = evt_vec[NUM_DIR-1:0];
        win_dir = DIR_UP;
        if (dir_evt[BTN_U]) begin
            win_dir = DIR_UP;
        end else if (dir_evt[BTN_D]) begin
            win_dir = DIR_DOWN;
        end else if (dir_evt[BTN_L]) begin
            win_dir = DIR_LEFT;
        end else if (dir_evt[BTN_R]) begin
            win_dir = DIR_RIGHT;
        end
        n_evt = 3'd0;
        for (int i = 0; i < NUM_DIR; i++) begin
            n_evt = n_evt + {2'b00, dir_evt[i]};
        end
        // Slot is free, or is being emptied this cycle (no bubble on back-to-back).
        can_load = !move_valid_q || move_ready;
        drop_inc = 3'd0;
        if (n_evt != 3'd0) begin
            drop_inc = can_load ? (n_evt - 3'd1) : n_evt;
        end
    end

    // Move request register, center pulse and saturating drop counter.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            move_valid_q <= 1'b0;
            move_dir_q   <= DIR_UP;
            center_q     <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            center_q   <= evt_vec[BTN_C];
            drop_cnt_q <= sat_add8(drop_cnt_q, drop_inc);
            if ((n_evt != 3'd0) && can_load) begin
                move_valid_q <= 1'b1;
                move_dir_q   <= win_dir;
            end else if (move_ready) begin
                move_valid_q <= 1'b0;
            end
        end
    end

    assign move_valid   = move_valid_q;
    assign move_dir     = move_dir_q;
    assign center_pulse = center_q;
    assign held         = held_vec;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_btn_move_ctrl.sv
// Self-checking bench for btn_move_ctrl with a run-length reference model.
module tb_btn_move_ctrl;

    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic       ClkPort = 1'b0;
    logic       Reset   = 1'b1;
    logic [4:0] btn     = 5'b00000;  // {C,R,L,D,U}
    logic       move_ready = 1'b0;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       center_pulse;
    logic [4:0] held;
    logic [7:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: synchronizer pipe, debounced level, run length of disagreeing
    // samples, and count of PRESSED cycles since the accepted press.
    logic [4:0] m_s1, m_s2;
    bit         m_lvl [5];
    int         m_run [5];
    int         m_h   [5];
    bit         m_valid;
    logic [1:0] m_dir;
    int         m_drop;
    bit         m_cp;

    always #5 ClkPort = ~ClkPort;

    btn_move_ctrl #(
        .DB_CYCLES (DB),
        .REP_DELAY (RD),
        .REP_PERIOD(RP)
    ) dut (
        .ClkPort     (ClkPort),
        .Reset       (Reset),
        .BtnU        (btn[0]),
        .BtnD        (btn[1]),
        .BtnL        (btn[2]),
        .BtnR        (btn[3]),
        .BtnC        (btn[4]),
        .move_ready  (move_ready),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .center_pulse(center_pulse),
        .held        (held),
        .drop_cnt    (drop_cnt)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit rep_due(input int h);
        return (h == RD) || ((h > RD) && ((h - RD) % RP == 0));
    endfunction

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        for (int b = 0; b < 5; b++) begin
            m_lvl[b] = 1'b0;
            m_run[b] = 0;
            m_h[b]   = 0;
        end
        m_valid = 1'b0;
        m_dir   = 2'b00;
        m_drop  = 0;
        m_cp    = 1'b0;
    endtask

    task automatic compare_all();
        logic [4:0] hv;
        for (int b = 0; b < 5; b++) hv[b] = m_lvl[b];
        check("move_valid", {7'b0, move_valid}, {7'b0, m_valid});
        check("move_dir", {6'b0, move_dir}, {6'b0, m_dir});
        check("center_pulse", {7'b0, center_pulse}, {7'b0, m_cp});
        check("held", {3'b0, held}, {3'b0, hv});
        check("drop_cnt", drop_cnt, 8'(m_drop));
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic tick();
        logic [4:0] ev;
        int n;
        @(posedge ClkPort);
        if (Reset) begin
            model_reset();
        end else begin
            ev = '0;
            for (int b = 0; b < 5; b++) begin
                if (b < 4 && m_lvl[b] && m_run[b] == 0) begin
                    m_h[b]++;
                    if (rep_due(m_h[b])) ev[b] = 1'b1;
                end
                if (m_s2[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB + 1) begin
                        m_lvl[b] = m_s2[b];
                        m_run[b] = 0;
                        if (m_lvl[b]) begin
                            m_h[b] = 0;
                            ev[b]  = 1'b1;
                        end
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_cp = ev[4];
            n = $countones(ev[3:0]);
            if (n > 0) begin
                if (!m_valid || move_ready) begin
                    m_valid = 1'b1;
                    for (int i = 3; i >= 0; i--) if (ev[i]) m_dir = 2'(i);
                    m_drop += n - 1;
                end else begin
                    m_drop += n;
                end
            end else if (move_ready) begin
                m_valid = 1'b0;
            end
            if (m_drop > 255) m_drop = 255;
            m_s2 = m_s1;
            m_s1 = btn;
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        int first;
        int nv;
        int np;
        int vt [$];

        // Reset state.
        model_reset();
        #1;
        compare_all();
        tick();
        tick();
        Reset = 1'b0;

        // Short 3-cycle glitch on U never debounces.
        btn = 5'b00001;
        repeat (3) tick();
        btn = 5'b00000;
        nv = 0;
        repeat (12) begin
            tick();
            nv += int'(move_valid) + int'(held != 0);
        end
        check("glitch_no_event", 8'(nv), 8'd0);

        // L held with ready=1: accept, two repeats, then release stops repeats.
        do_reset();
        move_ready = 1'b1;
        btn = 5'b00100;
        vt.delete();
        for (int t = 1; t <= 38; t++) begin
            tick();
            if (move_valid) vt.push_back(t);
        end
        btn = 5'b00000;
        for (int t = 39; t <= 60; t++) begin
            tick();
            if (move_valid) vt.push_back(t);
        end
        check("left_valid_count", 8'(vt.size()), 8'd3);
        if (vt.size() == 3) begin
            check("left_first_at", 8'(vt[0]), 8'd7);
            check("left_rep1_at", 8'(vt[1]), 8'd27);
            check("left_rep2_at", 8'(vt[2]), 8'd35);
        end

        // U and R in the same cycle: U wins, R dropped.
        do_reset();
        move_ready = 1'b0;
        btn = 5'b01001;
        repeat (10) tick();
        check("ur_valid", {7'b0, move_valid}, 8'd1);
        check("ur_dir", {6'b0, move_dir}, 8'd0);
        check("ur_drop", drop_cnt, 8'd1);
        btn = 5'b00000;
        repeat (8) tick();

        // Backpressure: D pending, R lost, then one ready cycle clears valid.
        do_reset();
        move_ready = 1'b0;
        btn = 5'b00010;
        repeat (10) tick();
        btn = 5'b01010;
        repeat (10) tick();
        check("bp_valid", {7'b0, move_valid}, 8'd1);
        check("bp_dir", {6'b0, move_dir}, 8'd1);
        check("bp_drop", drop_cnt, 8'd1);
        btn = 5'b00000;
        repeat (2) tick();
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        check("bp_cleared", {7'b0, move_valid}, 8'd0);
        repeat (8) tick();

        // Center held 60 cycles: one pulse, no move, no repeats.
        do_reset();
        move_ready = 1'b1;
        btn = 5'b10000;
        np = 0;
        nv = 0;
        repeat (60) begin
            tick();
            np += int'(center_pulse);
            nv += int'(move_valid);
        end
        btn = 5'b00000;
        repeat (10) begin
            tick();
            np += int'(center_pulse);
            nv += int'(move_valid);
        end
        check("center_pulses", 8'(np), 8'd1);
        check("center_no_move", 8'(nv), 8'd0);

        // Reset mid-press with D still held: full re-debounce afterwards.
        do_reset();
        move_ready = 1'b0;
        btn = 5'b00010;
        repeat (12) tick();
        do_reset();
        first = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (move_valid && first == 0) first = t;
        end
        check("reset_redebounce_at", 8'(first), 8'd7);
        btn = 5'b00000;
        repeat (8) tick();

        // Drop counter saturation with all directions held and no consumer.
        do_reset();
        move_ready = 1'b0;
        btn = 5'b01111;
        repeat (700) tick();
        check("drop_saturated", drop_cnt, 8'd255);
        btn = 5'b00000;
        move_ready = 1'b1;
        repeat (10) tick();

        // Randomized bouncing buttons and random backpressure.
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            btn = 5'($urandom);
            len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6))
                                               : int'($urandom_range(8, 45));
            repeat (len) begin
                move_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            if (seg == 30) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
